wash_done_alarm: RTL

- Downstream of the wash controller; consumes its `nxt` completion level.
- On a rising edge of `done`, plays a burst of audible beeps on a piezo buzzer pin and drives an alarm LED.
- The user silences it with a debounced button pulse.
- Re-arms only after `done` returns low, i.e. after a controller reset.

---
 rtl/wash_pkg.sv | 34 +++
 rtl/tone_gen.sv | 43 ++++
 rtl/wash_done_alarm.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wash_pkg.sv
// Shared definitions for the wash-done alarm: the alarm state encoding,
// default timing constants and small sizing helpers.
package wash_pkg;

    // Alarm sequencer states. The ST_ prefix keeps the labels apart from
    // the BEEP_ON / BEEP_OFF / GAP timing parameters of the top module.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BEEP_ON  = 3'd1,
        ST_BEEP_OFF = 3'd2,
        ST_GAP      = 3'd3,
        ST_HOLD     = 3'd4
    } alarm_state_t;

    // Default timing: 100 MHz system clock, 2 kHz buzzer tone.
    localparam int unsigned CLK_HZ        = 100_000_000;
    localparam int unsigned TONE_HZ       = 2000;
    localparam int unsigned DEF_TONE_HALF = CLK_HZ / (2 * TONE_HZ);

    // Width of a counter that must hold 0 .. n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Largest of three timer lengths, used to size the shared phase counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator for the piezo buzzer. While en is high the
// output toggles every TONE_HALF clocks, starting low; while en is low the
// counter and output are held clear so every beep starts from the same phase.
module tone_gen
    import wash_pkg::*;
#(
    parameter int unsigned TONE_HALF = DEF_TONE_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic buzz
);

    localparam int unsigned TW = cnt_width(TONE_HALF);
    localparam logic [TW-1:0] HALF_LAST = TW'(TONE_HALF - 1);

    logic [TW-1:0] tone_cnt;
    logic          buzz_q;

    // Half-period counter and toggle flop, cleared whenever the tone is off.
    // NOTE: clocked state is written only with non-blocking assignments so
    // every flop samples pre-edge values and simulation matches the netlist.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tone_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (!en) begin
            tone_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (tone_cnt == HALF_LAST) begin
            tone_cnt <= '0;
            buzz_q   <= ~buzz_q;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    // en is itself a flop in the sequencer, so gating here silences the pin
    // on the very cycle the beep ends rather than one clock later.
    assign buzz = buzz_q & en;

endmodule

// File: rtl/wash_done_alarm.sv
// Wash-done alarm: on a rising edge of the controller's completion level it
// plays N_BEEPS tone beeps, lights the alarm LED while each beep sounds and
// keeps the finished LED on until done drops. A button ack silences it.
// Optional macro ALARM_REPEAT_EN: instead of stopping after one burst, wait
// GAP cycles and start a fresh burst, repeating until ack or done low.
module wash_done_alarm
    import wash_pkg::*;
#(
    parameter int unsigned TONE_HALF = DEF_TONE_HALF,
    parameter int unsigned BEEP_ON   = 30_000_000,
    parameter int unsigned BEEP_OFF  = 20_000_000,
    parameter int unsigned N_BEEPS   = 5,
    parameter int unsigned GAP       = 300_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic done,
    input  logic ack,
    output logic buzz,
    output logic alarm_led,
    output logic fin_led,
    output logic active
);

    localparam int unsigned PW = cnt_width(max3(BEEP_ON, BEEP_OFF, GAP));
    localparam int unsigned BW = $clog2(N_BEEPS + 1);

    localparam logic [PW-1:0] ON_LAST  = PW'(BEEP_ON - 1);
    localparam logic [PW-1:0] OFF_LAST = PW'(BEEP_OFF - 1);
`ifdef ALARM_REPEAT_EN
    localparam logic [PW-1:0] GAP_LAST = PW'(GAP - 1);
`endif
    localparam logic [BW-1:0] BEEPS    = BW'(N_BEEPS);

    alarm_state_t  state;
    alarm_state_t  nxt;
    logic [PW-1:0] phase_cnt;
    logic [BW-1:0] beep_cnt;
    logic          done_q;
    logic          armed;
    logic          rise;
    logic          sounding;
    logic          nxt_sounding;

    // A rise only counts once done has been seen low since reset, so a level
    // that is already high when reset releases never starts a burst.
    assign rise     = done & ~done_q & armed;
    assign sounding = (state == ST_BEEP_ON) || (state == ST_BEEP_OFF) || (state == ST_GAP);
    assign nxt_sounding = (nxt == ST_BEEP_ON) || (nxt == ST_BEEP_OFF) || (nxt == ST_GAP);

    // Next-state decision: timer expiries first, then ack, then done-low,
    // so the later assignments win in that priority order.
    // NOTE: nxt is assigned a default before any branch so no path leaves
    // it holding its old value, which would otherwise infer a latch.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (rise) nxt = ST_BEEP_ON;
            end
            ST_BEEP_ON: begin
                if (phase_cnt == ON_LAST) nxt = ST_BEEP_OFF;
            end
            ST_BEEP_OFF: begin
                if (phase_cnt == OFF_LAST) begin
                    if (beep_cnt < BEEPS) begin
                        nxt = ST_BEEP_ON;
                    end else begin
`ifdef ALARM_REPEAT_EN
                        nxt = ST_GAP;
`else
                        nxt = ST_HOLD;
`endif
                    end
                end
            end
`ifdef ALARM_REPEAT_EN
            ST_GAP: begin
                if (phase_cnt == GAP_LAST) nxt = ST_BEEP_ON;
            end
`endif
            ST_HOLD: begin
                nxt = ST_HOLD;
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase

        if (sounding && ack) nxt = ST_HOLD;
        if ((state != ST_IDLE) && !done) nxt = ST_IDLE;
    end

    // Sequencer registers: state, timers, edge detector and the decoded
    // outputs, which are taken from nxt so they line up with the new state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            beep_cnt  <= '0;
            done_q    <= 1'b0;
            armed     <= 1'b0;
            alarm_led <= 1'b0;
            fin_led   <= 1'b0;
            active    <= 1'b0;
        end else begin
            done_q <= done;
            if (!done) armed <= 1'b1;

            state <= nxt;

            if (nxt != state) begin
                phase_cnt <= '0;
            end else if (sounding) begin
                phase_cnt <= phase_cnt + 1'b1;
            end

            // A burst starts from IDLE or GAP with count 1; each further
            // beep within the burst bumps it. It stops at N_BEEPS.
            if ((nxt == ST_BEEP_ON) && (state != ST_BEEP_ON)) begin
                if (state == ST_BEEP_OFF) begin
                    beep_cnt <= beep_cnt + 1'b1;
                end else begin
                    beep_cnt <= BW'(1);
                end
            end

            alarm_led <= (nxt == ST_BEEP_ON);
            active    <= nxt_sounding;
            fin_led   <= (nxt != ST_IDLE);
        end
    end

    tone_gen #(
        .TONE_HALF (TONE_HALF)
    ) u_tone_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (alarm_led),
        .buzz (buzz)
    );

endmodule
